oh_idlegate: RTL and testbench

Idle-detect and clock-gate sequencer that consumes the all-idle term produced by an `asic_nor4` over four busy flags. It registers that term, counts consecutive idle cycles up to a programmable threshold, then runs a four-phase sleep request/acknowledge handshake with the power/clock controller. It drops the gated-domain clock enable while asleep and restores it when any busy flag rises. The block sits in the always-on clock domain, in front of an `asic_icg`-style gate.

---
 rtl/oh_idlegate_pkg.sv | 13 +
 rtl/asic_nor4.sv | 19 +
 rtl/oh_idlegate.sv | 100 ++++++++++
 tb/tb_oh_idlegate.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/oh_idlegate_pkg.sv
// Shared definitions for the idle-detect / clock-gate sequencer.
package oh_idlegate_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_ACTIVE = 2'd0,
        ST_REQ    = 2'd1,
        ST_SLEEP  = 2'd2,
        ST_WAKE   = 2'd3
    } state_t;

endpackage

// File: rtl/asic_nor4.sv
// Four-input NOR cell; PROP selects a technology-specific implementation.
module asic_nor4 #(
    parameter PROP = "DEFAULT"
) (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic z
);

    // Only the generic variant exists today; library mappings slot in beside it.
    if (PROP == "DEFAULT") begin : g_generic
        assign z = ~(a | b | c | d);
    end else begin : g_other
        assign z = ~(a | b | c | d);
    end

endmodule

// File: rtl/oh_idlegate.sv
// Idle counter plus four-phase sleep request/acknowledge FSM driving a
// downstream clock-gate enable. Lives in the always-on clock domain.
module oh_idlegate
    import oh_idlegate_pkg::*;
#(
    parameter int CW   = 8,
    parameter     PROP = "DEFAULT"
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    busy,
    input  logic [CW-1:0] threshold,
    input  logic          sleep_ack,
    output logic          sleep_req,
    output logic          clk_en,
    output logic          idle,
    output logic          wake
);

    logic          w_all_idle;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_idle_q;
    logic          r_sleep_req;
    logic          r_clk_en;
    logic          r_wake;

    asic_nor4 #(
        .PROP (PROP)
    ) u_nor4 (
        .a (busy[0]),
        .b (busy[1]),
        .c (busy[2]),
        .d (busy[3]),
        .z (w_all_idle)
    );

    // NOTE: every state and output register is assigned with <= so all of
    // them update together from the values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_ACTIVE;
            r_cnt       <= '0;
            r_idle_q    <= 1'b0;
            r_sleep_req <= 1'b0;
            r_clk_en    <= 1'b1;
            r_wake      <= 1'b0;
        end else begin
            r_idle_q <= w_all_idle;
            r_wake   <= 1'b0;
            case (r_state)
                ST_ACTIVE: begin
                    if (!r_idle_q) begin
                        r_cnt <= '0;
                    end else if (r_cnt == threshold) begin
                        r_state     <= ST_REQ;
                        r_cnt       <= '0;
                        r_sleep_req <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_REQ: begin
                    // Busy takes priority over a simultaneous acknowledge.
                    if (!r_idle_q) begin
                        r_state     <= ST_WAKE;
                        r_sleep_req <= 1'b0;
                    end else if (sleep_ack) begin
                        r_state  <= ST_SLEEP;
                        r_clk_en <= 1'b0;
                    end
                end
                ST_SLEEP: begin
                    if (!r_idle_q) begin
                        r_state     <= ST_WAKE;
                        r_sleep_req <= 1'b0;
                        r_clk_en    <= 1'b1;
                        r_wake      <= 1'b1;
                    end
                end
                ST_WAKE: begin
                    // Hold here until the controller finishes its side of the handshake.
                    if (!sleep_ack) begin
                        r_state <= ST_ACTIVE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_ACTIVE;
                end
            endcase
        end
    end

    assign sleep_req = r_sleep_req;
    assign clk_en    = r_clk_en;
    assign idle      = r_idle_q;
    assign wake      = r_wake;

endmodule

// File: tb/tb_oh_idlegate.sv
// Directed bench for oh_idlegate: a per-cycle vector table plus hand-written
// sequences for counting, abort race, wake timing and reset.
module tb_oh_idlegate;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] busy;
    logic [7:0] threshold;
    logic       sleep_ack;
    logic       sleep_req;
    logic       clk_en;
    logic       idle;
    logic       wake;

    int total = 0;
    int bad   = 0;

    oh_idlegate #(
        .CW   (8),
        .PROP ("DEFAULT")
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .busy      (busy),
        .threshold (threshold),
        .sleep_ack (sleep_ack),
        .sleep_req (sleep_req),
        .clk_en    (clk_en),
        .idle      (idle),
        .wake      (wake)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] busy;
        logic       ack;
        logic       req;
        logic       en;
        logic       idl;
        logic       wk;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic req, input logic en,
                             input logic idl, input logic wk);
        check({name, " sleep_req"}, {7'd0, sleep_req}, {7'd0, req});
        check({name, " clk_en"},    {7'd0, clk_en},    {7'd0, en});
        check({name, " idle"},      {7'd0, idle},      {7'd0, idl});
        check({name, " wake"},      {7'd0, wake},      {7'd0, wk});
    endtask

    // Reset, then one busy cycle so idle_q is 0 and the block is in ACTIVE.
    task automatic start(input logic [7:0] thr);
        threshold = thr;
        reset     = 1'b1;
        busy      = 4'b0001;
        sleep_ack = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Drop busy at E0 and expect sleep_req to rise exactly after E(thr+1).
    task automatic count_to_req(input logic [7:0] thr, input string name);
        threshold = thr;
        busy      = 4'b0000;
        for (int i = 0; i <= int'(thr) + 1; i++) begin
            tick();
            check($sformatf("%s e%0d req", name, i), {7'd0, sleep_req},
                  {7'd0, (i == int'(thr) + 1)});
        end
        check({name, " idle"}, {7'd0, idle}, 8'd1);
    endtask

    task automatic go_sleep(input logic [7:0] thr, input string name);
        start(thr);
        count_to_req(thr, name);
        sleep_ack = 1'b1;
        tick();
        check_out({name, " sleep"}, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        busy      = 4'b0001;
        threshold = 8'd3;
        sleep_ack = 1'b0;

        //             rst   busy     ack   req   en    idle  wake
        vecs[0]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}; // E0
        vecs[3]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}; // E4: REQ
        vecs[7]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // SLEEP
        vecs[9]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // busy at E
        vecs[11] = '{1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}; // E+1: WAKE
        vecs[12] = '{1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // E+4: ACTIVE
        vecs[15] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        #2;
        for (int i = 0; i < 16; i++) begin
            reset     = vecs[i].rst;
            busy      = vecs[i].busy;
            sleep_ack = vecs[i].ack;
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].en,
                      vecs[i].idl, vecs[i].wk);
        end

        // Interrupted count: three idle edges, one busy edge, then a fresh run.
        start(8'd3);
        busy = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("intr run1 e%0d req", i), {7'd0, sleep_req}, 8'd0);
        end
        busy = 4'b1000;
        tick();
        check("intr busy req", {7'd0, sleep_req}, 8'd0);
        check("intr busy idle", {7'd0, idle}, 8'd0);
        count_to_req(8'd3, "intr run2");

        // Threshold extremes.
        start(8'd0);
        count_to_req(8'd0, "thr0");
        start(8'd255);
        count_to_req(8'd255, "thr255");

        // Abort race: busy reaches idle_q in REQ on the same edge ack arrives.
        start(8'd0);
        count_to_req(8'd0, "abort");
        busy = 4'b0010;
        tick();
        check_out("abort pre", 1'b1, 1'b1, 1'b0, 1'b0);
        sleep_ack = 1'b1;
        tick();
        check_out("abort race", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_out("abort hold", 1'b0, 1'b1, 1'b0, 1'b0);
        sleep_ack = 1'b0;
        tick();
        check_out("abort exit", 1'b0, 1'b1, 1'b0, 1'b0);
        busy = 4'b0001;
        tick();
        count_to_req(8'd0, "abort recount");

        // Wake with ack already low: WAKE lasts one cycle, then counting resumes.
        go_sleep(8'd1, "wk1");
        busy      = 4'b0001;
        sleep_ack = 1'b0;
        tick();
        check_out("wk1 e", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("wk1 e+1", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check_out("wk1 e+2", 1'b0, 1'b1, 1'b0, 1'b0);
        count_to_req(8'd0, "wk1 recount");

        // Reset while asleep with ack held high.
        go_sleep(8'd2, "rst");
        reset     = 1'b1;
        sleep_ack = 1'b1;
        busy      = 4'b0000;
        tick();
        check_out("rst asserted", 1'b0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        check_out("rst released", 1'b0, 1'b1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
